dtree_channel_scheduler: RTL and testbench

Time-shares a single dtree classifier among CHANNELS electrode channels. Each channel presents a complete feature vector. A round-robin arbiter grants one channel at a time and captures its vector. The block then streams the FEATURES samples serially into dtree's ready/valid port, waits for dtree's out_valid, and returns level/path tagged with the channel id, with a watchdog for a hung classifier.

---
 rtl/dtree_channel_scheduler.sv | 161 ++++++++++++++++
 tb/tb_dtree_channel_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_channel_scheduler.sv
// dtree_channel_scheduler
// Shares one dtree classifier between CHANNELS electrode channels. A
// round-robin arbiter picks one pending channel and copies its whole feature
// vector. The vector is then streamed one sample at a time into dtree. The
// block waits for the classification and returns it tagged with the channel id.
// A watchdog turns a classifier that never answers into a timeout result.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are 1. A valid, once raised, keeps its payload stable until that edge.
// There are three handshakes: ch_valid/ch_ready (grant),
// dt_valid/dt_ready (sample) and res_valid/res_ready (result).
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   ch_valid/ch_ready    per-channel request / one-hot grant (IDLE only)
//   ch_features          channel c, feature f at [(c*FEATURES+f)*IN_WIDTH +: IN_WIDTH]
//   dt_valid/dt_ready    sample stream to dtree, payload dt_sample
//   dt_level/dt_path     dtree result, qualified by dt_out_valid
//   res_*                tagged result; res_timeout marks a watchdog result
//   stray_err            sticky flag for dt_out_valid seen outside WAIT
//   busy                 state != IDLE
//   state_dbg            raw FSM state (0 IDLE, 1 SEND, 2 WAIT, 3 RESULT)
module dtree_channel_scheduler #(
  parameter int CHANNELS = 4,
  parameter int CH_WIDTH = 2,
  parameter int FEATURES = 3,
  parameter int IN_WIDTH = 10,
  parameter int TIMEOUT  = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [CHANNELS-1:0]                    ch_valid,
  output logic [CHANNELS-1:0]                    ch_ready,
  input  logic [CHANNELS*FEATURES*IN_WIDTH-1:0]  ch_features,
  input  logic                                   dt_ready,
  output logic                                   dt_valid,
  output logic [IN_WIDTH-1:0]                    dt_sample,
  input  logic [1:0]                             dt_level,
  input  logic [1:0]                             dt_path,
  input  logic                                   dt_out_valid,
  output logic                                   res_valid,
  input  logic                                   res_ready,
  output logic [CH_WIDTH-1:0]                    res_channel,
  output logic [1:0]                             res_level,
  output logic [1:0]                             res_path,
  output logic                                   res_timeout,
  output logic                                   stray_err,
  output logic                                   busy,
  output logic [1:0]                             state_dbg
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEND   = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  localparam int IDX_W = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [1:0]          state;
  logic [CH_WIDTH-1:0] last_grant;
  logic [CH_WIDTH-1:0] cur_ch;
  logic [IDX_W-1:0]    idx;
  logic [TMR_W-1:0]    timer;
  logic [IN_WIDTH-1:0] sample_buf [FEATURES];

  logic                win_found;
  logic [CH_WIDTH-1:0] win_ch;
  logic [CH_WIDTH-1:0] cand;

  // Search starts just after the last granted channel, so every channel is
  // served once per rotation. The rotation advances only on grants.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    cand      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = CH_WIDTH'((int'(last_grant) + 1 + i) % CHANNELS);
      if (!win_found && ch_valid[cand]) begin
        win_found = 1'b1;
        win_ch    = cand;
      end
    end
  end

  // The grant is gated by reset because the reset state is IDLE. Without the
  // gate, a channel holding ch_valid would see a grant while the block is
  // still held in reset.
  always_comb begin
    ch_ready = '0;
    if (state == S_IDLE && reset && win_found) ch_ready[win_ch] = 1'b1;
  end

  assign dt_valid  = (state == S_SEND);
  assign dt_sample = (state == S_SEND) ? sample_buf[idx] : '0;
  assign res_valid = (state == S_RESULT);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      last_grant  <= CH_WIDTH'(CHANNELS - 1);
      cur_ch      <= '0;
      idx         <= '0;
      timer       <= '0;
      res_channel <= '0;
      res_level   <= '0;
      res_path    <= '0;
      res_timeout <= 1'b0;
      stray_err   <= 1'b0;
      for (int f = 0; f < FEATURES; f++) sample_buf[f] <= '0;
    end else begin
      if (dt_out_valid && state != S_WAIT) stray_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (win_found) begin
            for (int f = 0; f < FEATURES; f++)
              sample_buf[f] <= ch_features[(int'(win_ch) * FEATURES + f) * IN_WIDTH +: IN_WIDTH];
            cur_ch     <= win_ch;
            last_grant <= win_ch;
            idx        <= '0;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (dt_ready) begin
            if (idx == IDX_W'(FEATURES - 1)) begin
              timer <= '0;
              state <= S_WAIT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          // A real answer wins over the watchdog when both occur in the same cycle.
          if (dt_out_valid) begin
            res_level   <= dt_level;
            res_path    <= dt_path;
            res_channel <= cur_ch;
            res_timeout <= 1'b0;
            state       <= S_RESULT;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            res_level   <= '0;
            res_path    <= '0;
            res_channel <= cur_ch;
            res_timeout <= 1'b1;
            state       <= S_RESULT;
          end
        end
        default: begin
          if (res_ready) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_channel_scheduler.sv
module tb_dtree_channel_scheduler;
  localparam int CH = 4;
  localparam int CW = 2;
  localparam int NF = 3;
  localparam int IW = 10;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [CH-1:0]         ch_valid, ch_ready;
  logic [CH*NF*IW-1:0]   ch_features;
  logic                  dt_ready, dt_valid, dt_out_valid;
  logic [IW-1:0]         dt_sample;
  logic [1:0]            dt_level, dt_path;
  logic                  res_valid, res_ready, res_timeout, stray_err, busy;
  logic [CW-1:0]         res_channel;
  logic [1:0]            res_level, res_path, state_dbg;

  dtree_channel_scheduler #(.CHANNELS(CH), .CH_WIDTH(CW), .FEATURES(NF),
                            .IN_WIDTH(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_features(ch_features), .dt_ready(dt_ready), .dt_valid(dt_valid),
    .dt_sample(dt_sample), .dt_level(dt_level), .dt_path(dt_path),
    .dt_out_valid(dt_out_valid), .res_valid(res_valid), .res_ready(res_ready),
    .res_channel(res_channel), .res_level(res_level), .res_path(res_path),
    .res_timeout(res_timeout), .stray_err(stray_err), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [6:0]    exp_q[$];   // {channel, level, path, timeout}
  logic [IW-1:0] samp_q[$];
  int res_cnt = 0;
  int xfers = 0;

  // dtree model and bench-side arbiter model
  logic [1:0] m_lvl, m_path;
  logic       m_respond;
  int         m_delay;
  int         fire_cnt;
  logic       model_ov, force_ov;
  logic [CW-1:0] m_lg;
  logic       m_busy;
  int         samp_seen;
  int         wait_cyc, rise_cyc;
  logic       res_prev, stall_prev;
  logic [IW-1:0] held;

  assign dt_out_valid = model_ov | force_ov;
  assign dt_level = m_lvl;
  assign dt_path  = m_path;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CH-1:0] rr(input logic [CH-1:0] v, input logic [CW-1:0] lg);
    logic [CH-1:0] g;
    logic [CW-1:0] c;
    logic found;
    g = '0;
    found = 1'b0;
    for (int i = 1; i <= CH; i++) begin
      c = CW'((int'(lg) + i) % CH);
      if (!found && v[c]) begin
        g[c] = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [CW-1:0] idx_of(input logic [CH-1:0] g);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) if (g[i]) r = CW'(i);
    return r;
  endfunction

  // ---------------- monitor / dtree model ----------------
  always @(negedge clk) begin
    logic [CH-1:0] eg;
    logic [CW-1:0] w;
    if (reset) begin
      model_ov = 1'b0;
      if (fire_cnt > 0) begin
        fire_cnt--;
        if (fire_cnt == 0) model_ov = m_respond;
      end

      eg = m_busy ? '0 : rr(ch_valid, m_lg);
      check("ch_ready", 32'(ch_ready), 32'(eg));
      check("busy", 32'(busy), 32'(m_busy));
      if (eg != '0) begin
        w = idx_of(eg);
        for (int f = 0; f < NF; f++)
          samp_q.push_back(ch_features[(int'(w) * NF + f) * IW +: IW]);
        m_lg = w;
        m_busy = 1'b1;
        samp_seen = 0;
      end

      if (stall_prev) check("dt_hold", 32'(dt_sample), 32'(held));
      stall_prev = dt_valid && !dt_ready;
      held = dt_sample;

      if (dt_valid && dt_ready) begin
        xfers++;
        if (samp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL dt_sample: unexpected sample %0d", dt_sample);
        end else begin
          check("dt_sample", 32'(dt_sample), 32'(samp_q.pop_front()));
        end
        samp_seen++;
        if (samp_seen == NF) begin
          fire_cnt = m_delay + 1;
          wait_cyc = cyc + 1;
        end
      end

      if (res_valid && !res_prev) rise_cyc = cyc;
      res_prev = res_valid;
      if (res_valid && res_ready) begin
        res_cnt++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL result: unexpected ch=%0d lvl=%0d path=%0d to=%0d",
                   res_channel, res_level, res_path, res_timeout);
        end else begin
          check("result", 32'({res_channel, res_level, res_path, res_timeout}), 32'(exp_q.pop_front()));
        end
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_model();
    exp_q.delete();
    samp_q.delete();
    fire_cnt = 0;
    model_ov = 1'b0;
    m_lg = CW'(CH - 1);
    m_busy = 1'b0;
    samp_seen = 0;
    res_prev = 1'b0;
    stall_prev = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic set_feat(input logic special);
    for (int c = 0; c < CH; c++)
      for (int f = 0; f < NF; f++)
        ch_features[(c * NF + f) * IW +: IW] = IW'(100 * c + f);
    if (special) begin
      ch_features[0 * IW +: IW] = IW'(5);
      ch_features[1 * IW +: IW] = IW'(300);
      ch_features[2 * IW +: IW] = IW'(1023);
    end
  endtask

  task automatic set_model(input logic [1:0] l, input logic [1:0] p, input logic r, input int d);
    m_lvl = l; m_path = p; m_respond = r; m_delay = d;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("result_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  typedef struct {
    logic [CH-1:0] chv;
    logic [1:0]    lvl;
    logic [1:0]    path;
    logic          respond;
    int            delay;
    logic [CW-1:0] exp_ch;
  } vec_t;

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[10];
    int   pat[5];
    int   x0, r0, n;

    vecs[0] = '{4'b1111, 2'd1, 2'd2, 1'b1, 0, 2'd0};
    vecs[1] = '{4'b1111, 2'd2, 2'd3, 1'b1, 0, 2'd1};
    vecs[2] = '{4'b1111, 2'd3, 2'd0, 1'b1, 2, 2'd2};
    vecs[3] = '{4'b1111, 2'd0, 2'd1, 1'b1, 0, 2'd3};
    vecs[4] = '{4'b1111, 2'd1, 2'd1, 1'b1, 0, 2'd0};
    vecs[5] = '{4'b1010, 2'd2, 2'd2, 1'b1, 0, 2'd1};
    vecs[6] = '{4'b1010, 2'd3, 2'd3, 1'b1, 1, 2'd3};
    vecs[7] = '{4'b0100, 2'd2, 2'd1, 1'b0, 0, 2'd2};
    vecs[8] = '{4'b1001, 2'd1, 2'd2, 1'b1, 0, 2'd3};
    vecs[9] = '{4'b1001, 2'd2, 2'd1, 1'b1, 0, 2'd0};
    pat = '{1, 0, 0, 1, 1};

    ch_valid = 4'b1111;
    dt_ready = 1'b1;
    res_ready = 1'b1;
    force_ov = 1'b0;
    set_model(2'd0, 2'd0, 1'b1, 0);
    set_feat(1'b0);
    reset = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    // outputs under reset, with every channel requesting
    check("rst_ch_ready", 32'(ch_ready), 32'd0);
    check("rst_dt_valid", 32'(dt_valid), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stray", 32'(stray_err), 32'd0);
    ch_valid = '0;
    reset = 1'b1;

    // single request on channel 0
    set_feat(1'b1);
    set_model(2'd2, 2'd1, 1'b1, 0);
    exp_q.push_back({2'd0, 2'd2, 2'd1, 1'b0});
    @(posedge clk); #1 ch_valid = 4'b0001;
    @(posedge clk); #1 ch_valid = '0;
    wait_done(100);

    // round-robin and mixed-request table, starting from a fresh rotation
    do_reset();
    set_feat(1'b0);
    foreach (vecs[i]) begin
      set_model(vecs[i].lvl, vecs[i].path, vecs[i].respond, vecs[i].delay);
      exp_q.push_back(vecs[i].respond ? {vecs[i].exp_ch, vecs[i].lvl, vecs[i].path, 1'b0}
                                      : {vecs[i].exp_ch, 2'd0, 2'd0, 1'b1});
      ch_valid = vecs[i].chv;
      wait_done(100);
    end
    ch_valid = '0;

    // watchdog: no answer, result exactly TIMEOUT cycles after entering WAIT
    set_model(2'd3, 2'd3, 1'b0, 0);
    exp_q.push_back({2'd1, 2'd0, 2'd0, 1'b1});
    ch_valid = 4'b0010;
    @(posedge clk); #1 ch_valid = '0;
    wait_done(100);
    check("timeout_latency", 32'(rise_cyc - wait_cyc), 32'(TO));

    // answer in the same cycle as the last watchdog count wins
    set_model(2'd3, 2'd2, 1'b1, TO - 1);
    exp_q.push_back({2'd2, 2'd3, 2'd2, 1'b0});
    ch_valid = 4'b0100;
    @(posedge clk); #1 ch_valid = '0;
    wait_done(100);
    check("late_answer_latency", 32'(rise_cyc - wait_cyc), 32'(TO));

    // dtree backpressure 1,0,0,1,1
    set_model(2'd1, 2'd1, 1'b1, 0);
    exp_q.push_back({2'd0, 2'd1, 2'd1, 1'b0});
    ch_valid = 4'b0001;
    @(posedge clk); #1 ch_valid = '0;
    x0 = xfers;
    for (int i = 0; i < 5; i++) begin
      dt_ready = pat[i][0];
      @(posedge clk); #1;
    end
    check("bp_transfers", 32'(xfers - x0), 32'd3);
    dt_ready = 1'b1;
    wait_done(100);

    // result stall: fields hold and no grant while res_ready=0
    res_ready = 1'b0;
    set_model(2'd2, 2'd1, 1'b1, 0);
    exp_q.push_back({2'd1, 2'd2, 2'd1, 1'b0});
    ch_valid = 4'b0010;
    n = 0;
    while (!res_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_res", 32'({res_valid, res_channel, res_level, res_path, res_timeout}),
            32'({1'b1, 2'd1, 2'd2, 2'd1, 1'b0}));
      check("stall_ch_ready", 32'(ch_ready), 32'd0);
    end
    ch_valid = '0;
    res_ready = 1'b1;
    wait_done(20);

    // stray dtree result while idle
    repeat (2) @(posedge clk);
    #1 check("stray_before", 32'(stray_err), 32'd0);
    r0 = res_cnt;
    force_ov = 1'b1;
    @(posedge clk); #1 force_ov = 1'b0;
    check("stray_set", 32'(stray_err), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("stray_sticky", 32'(stray_err), 32'd1);
    check("stray_no_result", 32'(res_cnt - r0), 32'd0);
    check("stray_idle", 32'(busy), 32'd0);

    // asynchronous reset in the middle of SEND, after two samples
    set_model(2'd3, 2'd3, 1'b1, 0);
    ch_valid = 4'b0001;
    @(posedge clk); #1 ch_valid = '0;
    x0 = xfers;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("areset_xfers", 32'(xfers - x0), 32'd2);
    check("areset_dt_valid", 32'(dt_valid), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_outs", 32'({ch_ready, dt_sample, res_valid, res_channel, res_level,
                              res_path, res_timeout, stray_err}), 32'd0);
    clear_model();
    @(posedge clk); #1 reset = 1'b1;
    r0 = res_cnt;
    set_model(2'd1, 2'd2, 1'b1, 0);
    exp_q.push_back({2'd1, 2'd1, 2'd2, 1'b0});
    ch_valid = 4'b0010;
    @(posedge clk); #1 ch_valid = '0;
    wait_done(100);
    repeat (20) @(posedge clk);
    #1 check("areset_one_result", 32'(res_cnt - r0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
